// File: rtl/seg7_decoder_if.sv
// rtl/seg7_decoder_if.sv - decoded digit-pair handshake bundle
interface seg7_decoder_if;
  logic [7:0] val_out;
  logic       val_valid;
  logic       val_ready;

  modport master (output val_out, output val_valid, input val_ready);
  modport slave  (input val_out, input val_valid, output val_ready);
endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - debounced 7-segment bus monitor producing hex digit pairs
module seg7_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           seg_in,
  seg7_decoder_if.master       val_if,
  output logic                 dig_err,
  output logic [6:0]           err_pattern,
  output logic                 overrun
);

  // Counter saturates at STABLE_CYCLES; the accepting sample is the one that
  // moves it from STABLE_CYCLES-2 to STABLE_CYCLES-1.
  localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES);
  localparam logic [15:0] ACC_AT  = 16'(STABLE_CYCLES - 2);

  logic [7:0]  sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  left_q, left_d, right_q, right_d;
  logic        left_seen_q, left_seen_d, right_seen_q, right_seen_d;
  logic [7:0]  val_out_q, val_out_d;
  logic        val_valid_q, val_valid_d;
  logic        dig_err_q, dig_err_d;
  logic [6:0]  err_pattern_q, err_pattern_d;
  logic        overrun_q, overrun_d;

  logic [6:0]  pat;
  logic        same, accept, pair_done, load;
  logic        dec_ok, dec_blank;
  logic [3:0]  dec_nib;

  assign pat = sync2_q[7:1];

  // Active-low a..g pattern to hex nibble; blank and unknown flagged separately
  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (pat)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      7'b1111111: begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default:    dec_ok = 1'b0;
    endcase
  end

  // Stability tracking, digit capture, pair assembly and output slot control
  always_comb begin
    same      = (sync2_q == prev_q);
    accept    = same && (cnt_q == ACC_AT);
    pair_done = left_seen_q && right_seen_q;
    load      = pair_done && (!val_valid_q || val_if.val_ready);

    cnt_d         = cnt_q;
    left_d        = left_q;
    right_d       = right_q;
    left_seen_d   = left_seen_q;
    right_seen_d  = right_seen_q;
    val_out_d     = val_out_q;
    val_valid_d   = val_valid_q;
    dig_err_d     = dig_err_q;
    err_pattern_d = err_pattern_q;
    overrun_d     = overrun_q;

    if (!same) begin
      cnt_d = 16'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (val_valid_q && val_if.val_ready) begin
      val_valid_d = 1'b0;
    end

    // A completed pair always frees the seen flags, even when it is dropped
    if (pair_done) begin
      left_seen_d  = 1'b0;
      right_seen_d = 1'b0;
      if (load) begin
        val_out_d   = {left_q, right_q};
        val_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // A digit accepted while the previous pair retires starts the next pair
    if (accept) begin
      if (dec_ok) begin
        if (sync2_q[0]) begin
          right_d      = dec_nib;
          right_seen_d = 1'b1;
        end else begin
          left_d      = dec_nib;
          left_seen_d = 1'b1;
        end
      end else if (!dec_blank) begin
        dig_err_d     = 1'b1;
        err_pattern_d = pat;
      end
    end
  end

  // State registers; synchronizer idles at the blank/right pattern
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q       <= 8'hFF;
      sync2_q       <= 8'hFF;
      prev_q        <= 8'hFF;
      cnt_q         <= 16'd0;
      left_q        <= 4'h0;
      right_q       <= 4'h0;
      left_seen_q   <= 1'b0;
      right_seen_q  <= 1'b0;
      val_out_q     <= 8'h00;
      val_valid_q   <= 1'b0;
      dig_err_q     <= 1'b0;
      err_pattern_q <= 7'h00;
      overrun_q     <= 1'b0;
    end else begin
      sync1_q       <= seg_in;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      cnt_q         <= cnt_d;
      left_q        <= left_d;
      right_q       <= right_d;
      left_seen_q   <= left_seen_d;
      right_seen_q  <= right_seen_d;
      val_out_q     <= val_out_d;
      val_valid_q   <= val_valid_d;
      dig_err_q     <= dig_err_d;
      err_pattern_q <= err_pattern_d;
      overrun_q     <= overrun_d;
    end
  end

  assign val_if.val_out   = val_out_q;
  assign val_if.val_valid = val_valid_q;
  assign dig_err          = dig_err_q;
  assign err_pattern      = err_pattern_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// tb/tb_seg7_decoder.sv - scoreboard bench for seg7_decoder
module tb_seg7_decoder;
  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] seg_in;
  logic       dig_err;
  logic [6:0] err_pattern;
  logic       overrun;

  seg7_decoder_if vif ();

  seg7_decoder #(.STABLE_CYCLES(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .seg_in     (seg_in),
    .val_if     (vif),
    .dig_err    (dig_err),
    .err_pattern(err_pattern),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic [6:0] code [16];
  logic [7:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int valid_cycles = 0;
  int vc0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] p, input logic s, input int n);
    seg_in = {p, s};
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    code[0]  = 7'b0000001; code[1]  = 7'b1001111; code[2]  = 7'b0010010; code[3]  = 7'b0000110;
    code[4]  = 7'b1001100; code[5]  = 7'b0100100; code[6]  = 7'b0100000; code[7]  = 7'b0001111;
    code[8]  = 7'b0000000; code[9]  = 7'b0000100; code[10] = 7'b0001000; code[11] = 7'b1100000;
    code[12] = 7'b0110001; code[13] = 7'b1000010; code[14] = 7'b0110000; code[15] = 7'b0111000;

    RST = 1'b1;
    seg_in = 8'hFF;
    vif.val_ready = 1'b1;

    // Monitor: pops the scoreboard on every handshake
    fork
      forever begin
        @(negedge CLK);
        if (!RST && vif.val_valid) valid_cycles++;
        if (!RST && vif.val_valid && vif.val_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pair: got %0h expected none", vif.val_out);
          end else begin
            check("pair_value", vif.val_out, exp_q.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(posedge CLK);
    #1;
    check("rst_val_valid", vif.val_valid, 0);
    check("rst_val_out", vif.val_out, 0);
    check("rst_dig_err", dig_err, 0);
    check("rst_err_pattern", err_pattern, 0);
    check("rst_overrun", overrun, 0);
    RST = 1'b0;

    // Post-reset blank must not yield anything
    vc0 = valid_cycles;
    drive(BLANK, 1'b1, 12);
    check("blank_no_valid", valid_cycles - vc0, 0);
    check("blank_no_err", dig_err, 0);

    // Left 2 then right 1 -> 8'h21
    vc0 = valid_cycles;
    exp_q.push_back(8'h21);
    drive(code[2], 1'b0, 10);
    drive(code[1], 1'b1, 10);
    check("p21_one_pulse", valid_cycles - vc0, 1);
    check("p21_dig_err", dig_err, 0);
    check("p21_drained", exp_q.size(), 0);

    // Toggling every 3 cycles never accepts; a 4-cycle code accepts at 2+4
    drive(code[0], 1'b0, 8);
    vc0 = valid_cycles;
    for (int k = 0; k < 6; k++) drive((k % 2 == 0) ? code[1] : code[2], 1'b1, 3);
    check("toggle_no_valid", valid_cycles - vc0, 0);
    exp_q.push_back(8'h05);
    seg_in = {code[5], 1'b1};
    repeat (4) @(posedge CLK);
    #1;
    seg_in = {BLANK, 1'b1};
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("lat_not_before", vif.val_valid, 0);
    @(negedge CLK);
    check("lat_valid_at", vif.val_valid, 1);
    drive(BLANK, 1'b1, 4);
    check("lat_drained", exp_q.size(), 0);

    // Invalid pattern sets the sticky error; blank afterwards changes nothing
    vc0 = valid_cycles;
    drive(7'b1010101, 1'b1, 10);
    check("inv_dig_err", dig_err, 1);
    check("inv_err_pattern", err_pattern, 7'b1010101);
    drive(BLANK, 1'b1, 10);
    check("inv_blank_pattern", err_pattern, 7'b1010101);
    check("inv_no_valid", valid_cycles - vc0, 0);

    // Two pairs with consumer stalled: second is dropped, overrun raised
    vif.val_ready = 1'b0;
    drive(code[5], 1'b0, 8);
    drive(code[10], 1'b1, 8);
    drive(code[12], 1'b0, 8);
    drive(code[3], 1'b1, 8);
    check("ovr_val_out", vif.val_out, 8'h5A);
    check("ovr_valid", vif.val_valid, 1);
    check("ovr_flag", overrun, 1);
    exp_q.push_back(8'h5A);
    vif.val_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("ovr_valid_clear", vif.val_valid, 0);
    check("ovr_drained", exp_q.size(), 0);

    // Reset discards a half pair
    drive(code[14], 1'b0, 10);
    drive(BLANK, 1'b1, 6);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst2_overrun", overrun, 0);
    check("rst2_dig_err", dig_err, 0);
    vc0 = valid_cycles;
    drive(code[3], 1'b1, 10);
    check("rst2_no_valid", valid_cycles - vc0, 0);
    exp_q.push_back(8'h73);
    drive(code[7], 1'b0, 10);
    check("rst2_drained", exp_q.size(), 0);

    // Sweep all codes on both digits
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({i[3:0], i[3:0]});
      drive(code[i], 1'b0, 6);
      drive(code[i], 1'b1, 6);
    end
    drive(BLANK, 1'b1, 20);
    check("sweep_drained", exp_q.size(), 0);
    check("final_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
